// File: rtl/blink_pkg.sv
// blink_pkg: shared register offsets and bit indices for the blink RTC block
// Holds the I/O register map offsets, TSTA status bit indices and CTL bit indices.
package blink_pkg;
  localparam logic [7:0] OFF_TIM0 = 8'd0;
  localparam logic [7:0] OFF_TIM1 = 8'd1;
  localparam logic [7:0] OFF_MIN0 = 8'd2;
  localparam logic [7:0] OFF_MIN1 = 8'd3;
  localparam logic [7:0] OFF_MIN2 = 8'd4;
  localparam logic [7:0] OFF_TSTA = 8'd5;
  localparam logic [7:0] OFF_TMK  = 8'd6;
  localparam logic [7:0] OFF_ALM0 = 8'd7;
  localparam logic [7:0] OFF_ALM1 = 8'd8;
  localparam logic [7:0] OFF_ALM2 = 8'd9;
  localparam logic [7:0] OFF_CTL  = 8'd10;
  localparam int TSTA_TICK  = 0;
  localparam int TSTA_SEC   = 1;
  localparam int TSTA_MIN   = 2;
  localparam int TSTA_ALM   = 3;
  localparam int CTL_FREEZE = 0;
  localparam int CTL_CLEAR  = 1;
endpackage

// File: rtl/blink_rtc_stage.sv
// rtc_stage: modulo-MODULUS counter stage used for the prescaler and every time counter
// Ports: mck clock; rin_n async active-low reset; inc count request; clr synchronous
//        zero (wins over inc); hold freezes the stage; q count; carry pulses on wrap.
module rtc_stage #(
  parameter int MODULUS = 2,
  parameter int W = 1
) (
  input  logic         mck,
  input  logic         rin_n,
  input  logic         inc,
  input  logic         clr,
  input  logic         hold,
  output logic [W-1:0] q,
  output logic         carry
);
  logic step;
  // A clear or a freeze swallows the increment, so no carry can escape either.
  assign step = inc & ~hold & ~clr;
  assign carry = step & (q == W'(MODULUS - 1));
  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) q <= '0;
    else if (clr) q <= '0;
    else if (step) q <= carry ? '0 : q + 1'b1;
endmodule

// File: rtl/blink_rtc.sv
// blink_rtc: prescaled tick/second/minute RTC with status, mask, minute alarm and snapshot reads
// Ports: mck clock; rin_n async active-low reset; io_addr/wr_stb/rd_stb/wdata I/O decode;
//        rdata/rd_hit registered read beat (one cycle after rd_stb); irq level interrupt.
module blink_rtc
  import blink_pkg::*;
#(
  parameter int         TICK_DIV      = 49153,
  parameter int         TICKS_PER_SEC = 200,
  parameter int         SEC_PER_MIN   = 60,
  parameter int         MIN_W         = 21,
  parameter logic [7:0] BASE          = 8'hD0
) (
  input  logic       mck,
  input  logic       rin_n,
  input  logic [7:0] io_addr,
  input  logic       wr_stb,
  input  logic       rd_stb,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rd_hit,
  output logic       irq
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SW = SEC_PER_MIN > 1 ? $clog2(SEC_PER_MIN) : 1;
  logic [PW-1:0]    pre_unused;
  logic [TW-1:0]    tim0;
  logic [SW-1:0]    tim1, sh_sec;
  logic [MIN_W-1:0] min_q, min_nxt, sh_min, alm, alm_nxt;
  logic [23:0]      sh_ext, alm_ext;
  logic [7:0]       off, rd_val;
  logic [3:0]       tsta, tmk, set_bits, w1c;
  logic             tick_ev, sec_ev, min_ev, min_wrap, alm_ev;
  logic             freeze, clear, in_map;
  assign off    = io_addr - BASE;
  assign in_map = off <= OFF_CTL;
  assign clear  = wr_stb & (off == OFF_CTL) & wdata[CTL_CLEAR];
  // Prescaler phase is internal only; just its terminal count leaves the stage.
  rtc_stage #(.MODULUS(TICK_DIV), .W(PW)) u_pre (
    .mck(mck), .rin_n(rin_n), .inc(1'b1), .clr(clear), .hold(freeze),
    .q(pre_unused), .carry(tick_ev)
  );
  rtc_stage #(.MODULUS(TICKS_PER_SEC), .W(TW)) u_tick (
    .mck(mck), .rin_n(rin_n), .inc(tick_ev), .clr(clear), .hold(freeze),
    .q(tim0), .carry(sec_ev)
  );
  rtc_stage #(.MODULUS(SEC_PER_MIN), .W(SW)) u_sec (
    .mck(mck), .rin_n(rin_n), .inc(sec_ev), .clr(clear), .hold(freeze),
    .q(tim1), .carry(min_ev)
  );
  rtc_stage #(.MODULUS(2 ** MIN_W), .W(MIN_W)) u_min (
    .mck(mck), .rin_n(rin_n), .inc(min_ev), .clr(clear), .hold(freeze),
    .q(min_q), .carry(min_wrap)
  );
  // The alarm compares against the minute value this event is about to produce.
  assign min_nxt = min_wrap ? '0 : min_q + 1'b1;
  assign alm_ev  = min_ev & (min_nxt == alm);
  assign irq     = |(tsta & tmk);
  assign w1c     = (wr_stb && off == OFF_TSTA) ? wdata[3:0] : 4'd0;
  assign sh_ext  = 24'(sh_min);
  assign alm_ext = 24'(alm);
  always_comb begin
    set_bits = '0;
    set_bits[TSTA_TICK] = tick_ev;
    set_bits[TSTA_SEC]  = sec_ev;
    set_bits[TSTA_MIN]  = min_ev;
    set_bits[TSTA_ALM]  = alm_ev;
  end
  // Each alarm bit is written only by the byte lane that covers it; bits past MIN_W do not exist.
  for (genvar g = 0; g < MIN_W; g++) begin : g_alm
    assign alm_nxt[g] = (wr_stb && off == OFF_ALM0 + 8'(g / 8)) ? wdata[g % 8] : alm[g];
  end
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_TIM0: rd_val = 8'(tim0);
      OFF_TIM1: rd_val = 8'(sh_sec);
      OFF_MIN0: rd_val = sh_ext[7:0];
      OFF_MIN1: rd_val = sh_ext[15:8];
      OFF_MIN2: rd_val = sh_ext[23:16];
      OFF_TSTA: rd_val = {4'd0, tsta};
      OFF_TMK:  rd_val = {4'd0, tmk};
      OFF_ALM0: rd_val = alm_ext[7:0];
      OFF_ALM1: rd_val = alm_ext[15:8];
      OFF_ALM2: rd_val = alm_ext[23:16];
      OFF_CTL:  rd_val = {7'd0, freeze};
      default:  rd_val = '0;
    endcase
  end
  always_ff @(posedge mck or negedge rin_n)
    if (!rin_n) begin
      tsta   <= '0;
      tmk    <= '0;
      alm    <= '0;
      freeze <= 1'b0;
      sh_sec <= '0;
      sh_min <= '0;
      rdata  <= '0;
      rd_hit <= 1'b0;
    end else begin
      // Set is OR-ed after the clear mask so a same-cycle event survives its W1C.
      tsta <= (tsta & ~w1c) | set_bits;
      alm  <= alm_nxt;
      if (wr_stb && off == OFF_TMK) tmk <= wdata[3:0];
      if (wr_stb && off == OFF_CTL) freeze <= wdata[CTL_FREEZE];
      // Reading the tick count freezes seconds and minutes for the following byte reads.
      if (rd_stb && off == OFF_TIM0) begin
        sh_sec <= tim1;
        sh_min <= min_q;
      end
      rd_hit <= rd_stb & in_map;
      if (rd_stb && in_map) rdata <= rd_val;
    end
endmodule
